seg_display_scan: RTL and testbench
===================================

Name: seg_display_scan

Overview:
- Consumes the 16-bit display register that the data-memory I/O window drives when software stores to the display address.
- Renders that value on an 8-digit, common-anode, multiplexed seven-segment display.
- Shows the value as 4-digit hex or 5-digit unsigned decimal. Decimal uses a sequential double-dabble converter.
- Optional leading-zero blanking; display contents update atomically.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit is driven before advancing the scan (must be >= 2).
- DIG_BITS, 3, scan index width (8 digits; fixed, not for override).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- value  in  16  display value from memory I/O stage (result).
- mode  in  1  0 = hex, 1 = unsigned decimal.
- blank_lz  in  1  1 = blank leading zeros.
- an  out  8  digit enables, active-low; an[0] = rightmost digit.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low; constant 1 (off).
- busy  out  1  update/conversion in progress.

Behaviour:

Reset (async, immediate):
- an=8'hFF, seg=7'h7F, dp=1, busy=0.
- held_value=0, held_mode=0; digit regs d0..d7=0; valid-digit count=4.
- Scan index=0, divider=0, FSM=IDLE.

Update FSM, states IDLE, CONV, LOAD; busy = (state != IDLE).
- IDLE:
  - If value != held_value or mode != held_mode: capture held_value<=value, held_mode<=mode.
  - Then go CONV if mode=1, else LOAD.
  - Otherwise stay in IDLE.
- CONV: double-dabble, 16 iterations, one per cycle.
  - Each cycle: add 3 to every 4-bit BCD nibble >= 5, then shift {bcd[19:0], bin[15:0]} left 1.
  - After the 16th shift, go LOAD.
  - BCD is 20 bits (5 digits; max 65535).
- LOAD (one cycle):
  - Hex mode: d0..d3 = held_value nibbles, count=4.
  - Decimal mode: d0..d4 = BCD digits, count=5.
  - Digits >= count are forced blank. All d regs are written in the same edge. Return to IDLE.
- Latency:
  - Hex: busy high exactly 1 cycle; new digits visible 2 edges after the changed value is sampled.
  - Decimal: busy high 17 cycles.
- Changes to value or mode while busy are ignored until IDLE. They are then re-compared, so the last value is always displayed eventually.
- blank_lz is applied combinationally at scan time, not captured.

Leading-zero blanking (blank_lz=1):
- Digit i (i>=1) is blank if d_i and every digit between i and count-1 are zero.
- Digit 0 is never blanked by this rule.

Scan:
- Divider counts 0..SCAN_DIV-1 continuously. On wrap, scan index increments, wrapping 7->0.
- an and seg are registered, updated at the edge after the index changes.
- an = ~(1<<index). Registered outputs apply the same skew to an and seg, so no ghosting.
- A blank digit still asserts its anode, with seg=7'h7F.

Hex font, active-low, seg[6:0]:
- 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
- 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- blank:7F

Reset mid-conversion:
- Abort to IDLE with all registers at reset values.
- The next compare after reset sees any value != 0 and restarts.

Test Plan:
All scenarios run with SCAN_DIV=4.

1. Reset, value=0, mode=0, blank_lz=0.
   -> During reset an=FF, seg=7F.
   -> After reset each of digits 0-3 shows seg=40 for 4 cycles, in sequence. Digits 4-7 show 7F. an walks FE,FD,…,7F, wrapping to FE.
2. mode=0, value=16'hBEEF.
   -> busy high 1 cycle.
   -> Digit0 seg=0E, digit1 06, digit2 06, digit3 03.
3. mode=1, value=16'd65535.
   -> busy high 17 cycles.
   -> Digits 0-4 show 5,3,5,5,6 (12,30,12,12,02); digits 5-7 show 7F.
4. mode=1, blank_lz=1, value=16'd7.
   -> Digit0 seg=78; digits 1-7 show 7F.
   -> Then value=0 -> digit0 shows 40.
5. mode=1, value=100, then value=200 on the 5th busy cycle.
   -> 100 is displayed (digits 0,0,1 = 40,40,79).
   -> Then a second 17-cycle busy.
   -> 200 is displayed (digit2 = 24).
6. Assert rst during the 8th CONV cycle.
   -> busy=0 and an=FF immediately, without waiting for a clock edge.
   -> After release with value=42, mode=1: digits show 2,4 (24,19) after 17 busy cycles.

Source files
------------

// File: rtl/seg_display_scan.sv
// Purpose : renders a 16-bit display register on an 8-digit common-anode
//           multiplexed seven-segment display, as 4-digit hex or 5-digit
//           unsigned decimal (sequential double-dabble), with optional
//           leading-zero blanking applied at scan time.
// Latency : hex update busy 1 cycle; decimal update busy 17 cycles; digits
//           switch atomically on the LOAD edge, segments follow one edge later.
// Backpressure: none; input changes seen while busy are re-compared once idle,
//           so the most recent value is always displayed eventually.
// Ports   : clk, rst (async active-high); value[15:0], mode (0 hex, 1 dec),
//           blank_lz; an[7:0] / seg[6:0] / dp active-low; busy = update running.
module seg_display_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIG_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        mode,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Update path state
  logic [1:0]  state_q, state_d;
  logic [15:0] held_value_q, held_value_d;
  logic        held_mode_q, held_mode_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [19:0] bcd_adj;
  logic [3:0]  iter_q, iter_d;
  logic [31:0] dig_q, dig_d;      // digit i lives in dig_q[4*i +: 4]
  logic [3:0]  count_q, count_d;  // number of valid digits (4 hex, 5 dec)

  // Scan path state
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIG_BITS-1:0] idx_q, idx_d;
  logic [7:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic       div_wrap;
  logic [7:0] blank_vec;
  logic [3:0] cur_digit;

  function automatic logic [6:0] hex_font(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift,
  // so that it carries correctly into the next decade after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < 5; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Update FSM
  always_comb begin
    state_d      = state_q;
    held_value_d = held_value_q;
    held_mode_d  = held_mode_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    dig_d        = dig_q;
    count_d      = count_q;
    case (state_q)
      ST_IDLE: begin
        if ((value != held_value_q) || (mode != held_mode_q)) begin
          held_value_d = value;
          held_mode_d  = mode;
          bin_d        = value;
          bcd_d        = '0;
          iter_d       = '0;
          state_d      = mode ? ST_CONV : ST_LOAD;
        end
      end
      ST_CONV: begin
        {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Whole digit vector replaced in one edge; unused digits cleared.
        if (held_mode_q) begin
          dig_d   = {12'h000, bcd_q};
          count_d = 4'd5;
        end else begin
          dig_d   = {16'h0000, held_value_q};
          count_d = 4'd4;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Blank mask: scan from the most significant valid digit downward; a digit
  // is a leading zero while no non-zero digit has been seen at or above it.
  always_comb begin
    logic nz;
    logic in_rng;
    nz        = 1'b0;
    in_rng    = 1'b0;
    blank_vec = '0;
    for (int i = 7; i >= 0; i--) begin
      in_rng = (4'(i) < count_q);
      if (in_rng && (dig_q[4*i +: 4] != 4'h0)) begin
        nz = 1'b1;
      end
      blank_vec[i] = !in_rng || (blank_lz && (i != 0) && !nz);
    end
  end

  // Scan divider and digit index
  assign div_wrap  = (div_q == DIV_W'(SCAN_DIV - 1));
  assign div_d     = div_wrap ? '0 : div_q + 1'b1;
  assign idx_d     = div_wrap ? idx_q + 1'b1 : idx_q;
  assign cur_digit = dig_q[{idx_q, 2'b00} +: 4];

  // an and seg are both derived from the same idx_q and registered together,
  // so the anode and its segment pattern always change on the same edge.
  assign an_d  = ~(8'd1 << idx_q);
  assign seg_d = blank_vec[idx_q] ? 7'h7F : hex_font(cur_digit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      held_value_q <= '0;
      held_mode_q  <= 1'b0;
      bin_q        <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      dig_q        <= '0;
      count_q      <= 4'd4;
      div_q        <= '0;
      idx_q        <= '0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
    end else begin
      state_q      <= state_d;
      held_value_q <= held_value_d;
      held_mode_q  <= held_mode_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      dig_q        <= dig_d;
      count_q      <= count_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seg_display_scan.sv
// Purpose : directed self-checking bench for seg_display_scan (SCAN_DIV=4).
// Latency : outputs sampled on the falling edge, inputs driven there too.
// Backpressure: n/a; every wait is bounded by a cycle budget.
module tb_seg_display_scan;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        mode;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int checks = 0;
  int errors = 0;

  seg_display_scan #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .mode     (mode),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count consecutive busy cycles starting from the next falling edge.
  task automatic busy_len(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
    end
    @(negedge clk);  // let seg pick up the freshly loaded digits
  endtask

  // Wait for digit d to be scanned and return its segment pattern.
  task automatic get_seg(input int d, output logic [6:0] s);
    logic [7:0] target;
    logic       found;
    target = ~(8'd1 << d);
    found  = 1'b0;
    s      = 7'h2A;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an == target) begin
        s     = seg;
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("scan_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_digit(input string tag, input int d, input logic [6:0] exp);
    logic [6:0] s;
    get_seg(d, s);
    chk(tag, {25'd0, s}, {25'd0, exp});
  endtask

  initial begin
    int         n;
    int         b1;
    int         b2;
    int         ph;
    logic [7:0] prev_an;
    logic [6:0] rec [8];
    logic [7:0] exp_an;
    logic [6:0] exp_seg;

    rst = 1'b1; value = 16'd0; mode = 1'b0; blank_lz = 1'b0;

    // 1. reset state, then idle scan of zero in hex
    repeat (3) @(negedge clk);
    chk("rst_an",   {24'd0, an},  32'hFF);
    chk("rst_seg",  {25'd0, seg}, 32'h7F);
    chk("rst_dp",   {31'd0, dp},  32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      exp_an  = ~(8'd1 << ((k / 4) % 8));
      exp_seg = (((k / 4) % 8) < 4) ? 7'h40 : 7'h7F;
      chk($sformatf("scan_an_%0d", k),  {24'd0, an},  {24'd0, exp_an});
      chk($sformatf("scan_seg_%0d", k), {25'd0, seg}, {25'd0, exp_seg});
    end
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 2. hex BEEF
    value = 16'hBEEF; mode = 1'b0;
    busy_len(n);
    chk("hex_busy_len", n, 32'd1);
    chk_digit("hex_d0", 0, 7'h0E);
    chk_digit("hex_d1", 1, 7'h06);
    chk_digit("hex_d2", 2, 7'h06);
    chk_digit("hex_d3", 3, 7'h03);
    chk_digit("hex_d4", 4, 7'h7F);

    // 3. decimal 65535
    value = 16'd65535; mode = 1'b1;
    busy_len(n);
    chk("dec_busy_len", n, 32'd17);
    chk_digit("dec_d0", 0, 7'h12);
    chk_digit("dec_d1", 1, 7'h30);
    chk_digit("dec_d2", 2, 7'h12);
    chk_digit("dec_d3", 3, 7'h12);
    chk_digit("dec_d4", 4, 7'h02);
    chk_digit("dec_d5", 5, 7'h7F);
    chk_digit("dec_d7", 7, 7'h7F);

    // 4. leading-zero blanking
    blank_lz = 1'b1; value = 16'd7;
    busy_len(n);
    chk("lz7_busy_len", n, 32'd17);
    chk_digit("lz7_d0", 0, 7'h78);
    chk_digit("lz7_d1", 1, 7'h7F);
    chk_digit("lz7_d4", 4, 7'h7F);
    chk_digit("lz7_d6", 6, 7'h7F);
    value = 16'd0;
    busy_len(n);
    chk("lz0_busy_len", n, 32'd17);
    chk_digit("lz0_d0", 0, 7'h40);
    chk_digit("lz0_d1", 1, 7'h7F);
    blank_lz = 1'b0;

    // 5. change while busy: start aligned to the digit-3 slot so the
    //    window in which 100 is shown spans digits 0..2
    prev_an = an;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an == 8'hF7 && prev_an != 8'hF7) break;
      prev_an = an;
    end
    for (int d = 0; d < 8; d++) rec[d] = 7'h2A;
    value = 16'd100;
    b1 = 0; b2 = 0; ph = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ph == 0) begin
        if (busy) begin
          b1++;
          if (b1 == 5) value = 16'd200;
        end else if (b1 > 0) ph = 1;
      end else begin
        if (ph == 2 && !busy) break;
        if (busy) begin
          ph = 2;
          b2++;
        end
        for (int d = 0; d < 8; d++) if (an == ~(8'd1 << d)) rec[d] = seg;
      end
    end
    chk("chg_busy1", b1, 32'd17);
    chk("chg_busy2", b2, 32'd17);
    chk("v100_d0", {25'd0, rec[0]}, 32'h40);
    chk("v100_d1", {25'd0, rec[1]}, 32'h40);
    chk("v100_d2", {25'd0, rec[2]}, 32'h79);
    @(negedge clk);
    chk_digit("v200_d2", 2, 7'h24);
    chk_digit("v200_d0", 0, 7'h40);

    // 6. reset during the 8th conversion cycle
    value = 16'd999;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (n == 8) break;
    end
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_an",   {24'd0, an},  32'hFF);
    chk("midrst_seg",  {25'd0, seg}, 32'h7F);
    value = 16'd42; mode = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    busy_len(n);
    chk("post_rst_busy_len", n, 32'd17);
    chk_digit("v42_d0", 0, 7'h24);
    chk_digit("v42_d1", 1, 7'h19);
    chk_digit("v42_d2", 2, 7'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
